riscv_lsu_stage: RTL and testbench
==================================

Name: riscv_lsu_stage

Overview:
- MEM stage of the 5-stage riscv_cpu pipeline.
- Sits between EX and WB: consumes the EX/MEM payload (address = alu_result, store data, dest_reg, ctl bits) and produces the MEM/WB payload (alu_result, mem_data, dest_reg, reg_we, wdata_mux).
- Runs the data-memory req/gnt/rvalid handshake, generates byte enables, replicates store data, and aligns/extends load data.
- Stalls EX via ex_ready_o while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported.
ADDR_WIDTH, 5, register-index width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ex_valid_i  in  1  EX payload valid
ex_ready_o  out  1  stage can accept a payload (EX holds otherwise)
ex_mem_en_i  in  1  payload is a load/store
ex_mem_we_i  in  1  1 = store, 0 = load
ex_funct3_i  in  3  LB/LH/LW/LBU/LHU or SB/SH/SW encoding
ex_alu_result_i  in  32  effective address or ALU result
ex_mem_wdata_i  in  32  store data (rs2)
ex_dest_reg_i  in  ADDR_WIDTH  destination register
ex_reg_we_i  in  1  register write enable
ex_wdata_mux_i  in  1  WDATA_ALU / WDATA_MEM
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_addr_o  out  32  word-aligned address
data_we_o  out  1  bus write
data_be_o  out  4  byte enables
data_wdata_o  out  32  bus write data
data_rdata_i  in  32  bus read data
wb_valid_o  out  1  MEM/WB payload valid (one-cycle pulse per payload)
wb_dest_reg_o  out  ADDR_WIDTH  destination register
wb_reg_we_o  out  1  register write enable
wb_wdata_mux_o  out  1  forwarded wdata_mux
wb_alu_result_o  out  32  forwarded ALU result
wb_mem_data_o  out  32  formatted load data

Behaviour:
- Reset (async, rst_ni=0): FSM -> IDLE. All outputs are 0 except ex_ready_o, which is 1.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - ex_ready_o = 1.
  - On ex_valid_i & !ex_mem_en_i: register the payload into the WB outputs and pulse wb_valid_o next cycle. Latency 1; back-to-back non-memory ops run at full throughput.
  - On ex_valid_i & ex_mem_en_i: capture the op into internal registers and go to REQ.
- REQ:
  - data_req_o = 1, driven only from the captured registers.
  - data_addr_o = {addr[31:2], 2'b00}.
  - Hold all request signals stable until data_gnt_i = 1, then go to RESP.
- RESP:
  - data_req_o = 0.
  - Wait for data_rvalid_i. rvalid is never sampled in the grant cycle.
  - On rvalid: format the data, pulse wb_valid_o next cycle, and return to IDLE.
  - Stores also wait for rvalid. For stores wb_mem_data_o = 0 and wb_reg_we_o follows ex_reg_we_i (0 from the decoder).
- ex_ready_o = 0 in REQ and in RESP.
- Minimum memory-op latency: accept at T, req+gnt at T+1, rvalid at T+2, wb_valid_o at T+3.
- Byte enables and store data (off = addr[1:0]):
  - SB: be = 4'b0001 << off; wdata = byte replicated x4.
  - SH: be = 4'b0011 << {off[1], 1'b0}; wdata = halfword replicated x2.
  - SW and any other funct3: be = 4'b1111; wdata = rs2 unchanged.
- Load formatting:
  - LB/LBU: select byte at off; sign-extend / zero-extend.
  - LH/LHU: select halfword at off[1]; sign-extend / zero-extend.
  - LW and any other funct3: full word.
- Misalignment without the option below:
  - Halfword accesses ignore off[0]; word accesses ignore off entirely.
  - The access completes normally at the aligned location.
- wb_alu_result_o always carries the captured address/ALU result. wb_* outputs hold their value between pulses.
- Reset mid-operation: data_req_o drops immediately (asynchronously) and the outstanding response is discarded. The bus is expected to be reset concurrently.
- ex_valid_i is ignored whenever ex_ready_o = 0.

Optional Feature:
- Macro: RISCV_CPU_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds ports misaligned_o (out, 1) and misaligned_addr_o (out, 32).
  - A misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) is detected in IDLE and never goes to REQ; no bus request is issued.
  - Next cycle: wb_valid_o = 1, misaligned_o = 1, misaligned_addr_o = address, wb_reg_we_o forced to 0.
  - misaligned_o is 0 otherwise; both new outputs reset to 0.
- Undefined: the ports are absent and accesses are silently aligned as described in Behaviour.

Test Plan:
- Non-mem burst: 3 consecutive ALU payloads (results 0x11, 0x22, 0x33) -> wb_valid_o on 3 consecutive cycles with the same values; ex_ready_o stays 1.
- LB at 0x1003, rdata=0x80FF_FF_FF, gnt and rvalid immediate -> data_addr_o=0x1000, be=4'b1111 bus-ignored; wb_mem_data_o=0xFFFF_FF80 at T+3. LBU same -> 0x0000_0080.
- SH at 0x2002, rs2=0xDEAD_BEEF, gnt delayed 3 cycles -> req and address held stable; data_be_o=4'b1100, data_wdata_o=0xBEEF_BEEF; ex_ready_o low until wb_valid_o.
- LHU at 0x3002, rdata=0x8765_4321, rvalid 4 cycles after gnt -> wb_mem_data_o=0x0000_8765; no second wb_valid_o.
- Reset asserted in RESP -> data_req_o=0, ex_ready_o=1, wb_valid_o=0 immediately; a later rvalid is ignored.
- With RISCV_CPU_LSU_MISALIGN_TRAP_EN: LW at 0x4001 -> no data_req_o; misaligned_o=1, misaligned_addr_o=0x4001, wb_reg_we_o=0 one cycle after accept.

Source files
------------

// File: rtl/riscv_lsu_stage.sv
// riscv_lsu_stage: MEM stage running the data-bus req/gnt/rvalid handshake and load/store formatting.
// Optional misaligned-access trap is enabled with `define RISCV_CPU_LSU_MISALIGN_TRAP_EN.
module riscv_lsu_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_mem_en_i,
    input  logic                  ex_mem_we_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
    input  logic [DATA_WIDTH-1:0] ex_mem_wdata_i,
    input  logic [ADDR_WIDTH-1:0] ex_dest_reg_i,
    input  logic                  ex_reg_we_i,
    input  logic                  ex_wdata_mux_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
    output logic                  misaligned_o,
    output logic [DATA_WIDTH-1:0] misaligned_addr_o,
`endif
    output logic                  wb_valid_o,
    output logic [ADDR_WIDTH-1:0] wb_dest_reg_o,
    output logic                  wb_reg_we_o,
    output logic                  wb_wdata_mux_o,
    output logic [DATA_WIDTH-1:0] wb_alu_result_o,
    output logic [DATA_WIDTH-1:0] wb_mem_data_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            st;
    logic                  op_we;
    logic [2:0]            op_f3;
    logic [DATA_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [ADDR_WIDTH-1:0] op_dest;
    logic                  op_reg_we;
    logic                  op_mux;
    logic [1:0]            off;
    logic [3:0]            be_raw;
    logic [DATA_WIDTH-1:0] wd_raw;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;
    logic [DATA_WIDTH-1:0] ld_fmt;
    logic                  mis;

    always_comb begin
        off    = op_addr[1:0];
        be_raw = !op_we ? 4'b1111 :
                 op_f3 == 3'b000 ? 4'b0001 << off :
                 op_f3 == 3'b001 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
        wd_raw = op_f3 == 3'b000 ? {4{op_wdata[7:0]}} :
                 op_f3 == 3'b001 ? {2{op_wdata[15:0]}} : op_wdata;
        rd_sh  = data_rdata_i >> {off, 3'b000};
        ld_b   = rd_sh[7:0];
        ld_h   = off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        ld_fmt = op_we ? '0 :
                 op_f3 == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
                 op_f3 == 3'b100 ? {24'b0, ld_b} :
                 op_f3 == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
                 op_f3 == 3'b101 ? {16'b0, ld_h} : data_rdata_i;
    end

`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
    assign mis = ex_mem_en_i && ((ex_funct3_i[1:0] == 2'b01 && ex_alu_result_i[0]) ||
                                 (ex_funct3_i == 3'b010 && ex_alu_result_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Bus outputs come only from the captured op and are zero outside REQ.
    assign ex_ready_o   = st == IDLE;
    assign data_req_o   = st == REQ;
    assign data_addr_o  = data_req_o ? {op_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign data_we_o    = data_req_o & op_we;
    assign data_be_o    = data_req_o ? be_raw : 4'b0000;
    assign data_wdata_o = data_req_o ? wd_raw : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st              <= IDLE;
            op_we           <= 1'b0;
            op_f3           <= 3'b000;
            op_addr         <= '0;
            op_wdata        <= '0;
            op_dest         <= '0;
            op_reg_we       <= 1'b0;
            op_mux          <= 1'b0;
            wb_valid_o      <= 1'b0;
            wb_dest_reg_o   <= '0;
            wb_reg_we_o     <= 1'b0;
            wb_wdata_mux_o  <= 1'b0;
            wb_alu_result_o <= '0;
            wb_mem_data_o   <= '0;
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
            if (st == IDLE) begin
                if (ex_valid_i) begin
                    op_we     <= ex_mem_we_i;
                    op_f3     <= ex_funct3_i;
                    op_addr   <= ex_alu_result_i;
                    op_wdata  <= ex_mem_wdata_i;
                    op_dest   <= ex_dest_reg_i;
                    op_reg_we <= ex_reg_we_i;
                    op_mux    <= ex_wdata_mux_i;
                    if (!ex_mem_en_i || mis) begin
                        wb_valid_o      <= 1'b1;
                        wb_dest_reg_o   <= ex_dest_reg_i;
                        wb_reg_we_o     <= ex_reg_we_i & ~mis;
                        wb_wdata_mux_o  <= ex_wdata_mux_i;
                        wb_alu_result_o <= ex_alu_result_i;
                        wb_mem_data_o   <= '0;
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
                        misaligned_o <= mis;
                        if (mis) misaligned_addr_o <= ex_alu_result_i;
`endif
                    end else begin
                        st <= REQ;
                    end
                end
            end else if (st == REQ) begin
                if (data_gnt_i) st <= RESP;
            end else if (data_rvalid_i) begin
                st              <= IDLE;
                wb_valid_o      <= 1'b1;
                wb_dest_reg_o   <= op_dest;
                wb_reg_we_o     <= op_reg_we;
                wb_wdata_mux_o  <= op_mux;
                wb_alu_result_o <= op_addr;
                wb_mem_data_o   <= ld_fmt;
            end
        end
    end
endmodule

// File: tb/tb_riscv_lsu_stage.sv
// tb_riscv_lsu_stage: scoreboard bench for the MEM stage handshake and formatting.
module tb_riscv_lsu_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_en, ex_mem_we, ex_reg_we, ex_mux;
    logic [2:0]  ex_f3;
    logic [31:0] ex_alu, ex_wd;
    logic [4:0]  ex_dest;
    logic        req, gnt, rvalid, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        wb_valid, wb_reg_we, wb_mux;
    logic [4:0]  wb_dest;
    logic [31:0] wb_alu, wb_mem;
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
    logic        misaligned;
    logic [31:0] misaligned_addr;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dest;
        logic        reg_we;
        logic        mux;
    } wb_t;

    wb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    riscv_lsu_stage dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_mem_en_i(ex_mem_en), .ex_mem_we_i(ex_mem_we),
        .ex_funct3_i(ex_f3), .ex_alu_result_i(ex_alu), .ex_mem_wdata_i(ex_wd), .ex_dest_reg_i(ex_dest),
        .ex_reg_we_i(ex_reg_we), .ex_wdata_mux_i(ex_mux),
        .data_req_o(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_addr_o(addr), .data_we_o(we),
        .data_be_o(be), .data_wdata_o(wdata), .data_rdata_i(rdata),
`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
        .misaligned_o(misaligned), .misaligned_addr_o(misaligned_addr),
`endif
        .wb_valid_o(wb_valid), .wb_dest_reg_o(wb_dest), .wb_reg_we_o(wb_reg_we), .wb_wdata_mux_o(wb_mux),
        .wb_alu_result_o(wb_alu), .wb_mem_data_o(wb_mem)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_spurious", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_alu", wb_alu, e.alu);
                check("wb_mem", wb_mem, e.mem);
                check("wb_dest", {27'b0, wb_dest}, {27'b0, e.dest});
                check("wb_reg_we", {31'b0, wb_reg_we}, {31'b0, e.reg_we});
                check("wb_mux", {31'b0, wb_mux}, {31'b0, e.mux});
            end
        end
    end

    task automatic mem_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int rv, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_mem, input logic [4:0] dest);
        wb_t e;
        check("ready_idle", {31'b0, ex_ready}, 32'd1);
        ex_valid = 1; ex_mem_en = 1; ex_mem_we = st; ex_f3 = f3; ex_alu = a; ex_wd = wd;
        ex_dest = dest; ex_reg_we = !st; ex_mux = !st;
        e.alu = a; e.mem = exp_mem; e.dest = dest; e.reg_we = !st; e.mux = !st;
        sb.push_back(e);
        step();
        ex_valid = 0; ex_alu = ~a; ex_wd = ~wd; ex_f3 = 3'b111;
        for (int i = 0; i <= gd; i++) begin
            check("req_high", {31'b0, req}, 32'd1);
            check("req_addr", addr, {a[31:2], 2'b00});
            check("req_we", {31'b0, we}, {31'b0, st});
            check("req_be", {28'b0, be}, {28'b0, exp_be});
            if (st) check("req_wdata", wdata, exp_wd);
            check("ready_req", {31'b0, ex_ready}, 32'd0);
            if (i == gd) gnt = 1;
            step();
        end
        gnt = 0;
        for (int i = 0; i <= rv; i++) begin
            check("req_low_resp", {31'b0, req}, 32'd0);
            check("ready_resp", {31'b0, ex_ready}, 32'd0);
            check("wb_idle_resp", {31'b0, wb_valid}, 32'd0);
            if (i == rv) begin rvalid = 1; rdata = rd; end
            step();
        end
        rvalid = 0; rdata = 32'h5A5A_5A5A;
        check("wb_pulse", {31'b0, wb_valid}, 32'd1);
        check("ready_back", {31'b0, ex_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 0; ex_valid = 0; ex_mem_en = 0; ex_mem_we = 0; ex_f3 = 0; ex_alu = 0; ex_wd = 0;
        ex_dest = 0; ex_reg_we = 0; ex_mux = 0; gnt = 0; rvalid = 0; rdata = 0;
        step(); step();
        check("rst_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_be", {28'b0, be}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_alu", wb_alu, 32'd0);
        rst_n = 1;
        step();

        for (int i = 1; i <= 3; i++) begin
            wb_t e;
            check("ready_burst", {31'b0, ex_ready}, 32'd1);
            ex_valid = 1; ex_mem_en = 0; ex_alu = 32'h11 * i; ex_dest = 5'(i); ex_reg_we = 1; ex_mux = 0;
            e.alu = 32'h11 * i; e.mem = 0; e.dest = 5'(i); e.reg_we = 1; e.mux = 0;
            sb.push_back(e);
            step();
            if (i > 1) check("burst_pulse", {31'b0, wb_valid}, 32'd1);
        end
        ex_valid = 0;
        check("burst_last", {31'b0, wb_valid}, 32'd1);
        check("burst_ready", {31'b0, ex_ready}, 32'd1);
        step();

        mem_op(0, 3'b000, 32'h1003, 0, 32'h80FF_FFFF, 0, 0, 4'b1111, 0, 32'hFFFF_FF80, 5'd4);
        mem_op(0, 3'b100, 32'h1003, 0, 32'h80FF_FFFF, 0, 0, 4'b1111, 0, 32'h0000_0080, 5'd5);
        mem_op(1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 0, 3, 0, 4'b1100, 32'hBEEF_BEEF, 0, 5'd0);
        mem_op(0, 3'b101, 32'h3002, 0, 32'h8765_4321, 0, 4, 4'b1111, 0, 32'h0000_8765, 5'd6);
        mem_op(0, 3'b001, 32'h3002, 0, 32'h8765_4321, 1, 1, 4'b1111, 0, 32'hFFFF_8765, 5'd7);
        mem_op(1, 3'b000, 32'h5001, 32'h1234_5678, 0, 0, 2, 4'b0010, 32'h7878_7878, 0, 5'd0);
        mem_op(1, 3'b010, 32'h6004, 32'hA5A5_0F0F, 0, 2, 0, 4'b1111, 32'hA5A5_0F0F, 0, 5'd0);
        mem_op(0, 3'b010, 32'h7000, 0, 32'hCAFE_BABE, 0, 0, 4'b1111, 0, 32'hCAFE_BABE, 5'd8);
        mem_op(0, 3'b100, 32'h1001, 0, 32'h0000_7F00, 0, 0, 4'b1111, 0, 32'h0000_007F, 5'd9);
`ifndef RISCV_CPU_LSU_MISALIGN_TRAP_EN
        mem_op(0, 3'b101, 32'h3001, 0, 32'h8765_4321, 0, 0, 4'b1111, 0, 32'h0000_4321, 5'd10);
`endif

        ex_valid = 1; ex_mem_en = 1; ex_mem_we = 0; ex_f3 = 3'b010; ex_alu = 32'h8000; ex_dest = 5'd11;
        step();
        ex_valid = 0; gnt = 1;
        step();
        gnt = 0;
        rst_n = 0;
        #1;
        check("rst_mid_req", {31'b0, req}, 32'd0);
        check("rst_mid_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_mid_wb", {31'b0, wb_valid}, 32'd0);
        step();
        rst_n = 1;
        step();
        rvalid = 1; rdata = 32'h1111_2222;
        step();
        rvalid = 0;
        check("late_rvalid_wb", {31'b0, wb_valid}, 32'd0);
        check("late_rvalid_ready", {31'b0, ex_ready}, 32'd1);

`ifdef RISCV_CPU_LSU_MISALIGN_TRAP_EN
        begin
            wb_t e;
            ex_valid = 1; ex_mem_en = 1; ex_mem_we = 0; ex_f3 = 3'b010; ex_alu = 32'h4001;
            ex_dest = 5'd12; ex_reg_we = 1; ex_mux = 1;
            e.alu = 32'h4001; e.mem = 0; e.dest = 5'd12; e.reg_we = 0; e.mux = 1;
            sb.push_back(e);
            step();
            ex_valid = 0;
            check("mis_flag", {31'b0, misaligned}, 32'd1);
            check("mis_addr", misaligned_addr, 32'h4001);
            check("mis_noreq", {31'b0, req}, 32'd0);
            check("mis_wb", {31'b0, wb_valid}, 32'd1);
            step();
            check("mis_clear", {31'b0, misaligned}, 32'd0);
            check("mis_noreq2", {31'b0, req}, 32'd0);
        end
`endif

        step(); step();
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
